// File: rtl/regfile_verify_harness.sv
// Self-check sequencer: runs the core for a set number of cycles and logs writebacks to a trace FIFO.
// It then scans every register through read port A against an expected-value memory.
module regfile_verify_harness #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned CYCLE_W     = 16,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  input  logic               rwe,
  input  logic [ADDR_W-1:0]  rd,
  input  logic [DATA_W-1:0]  rData,
  output logic               test_mode,
  output logic [ADDR_W-1:0]  rs1_test,
  input  logic [DATA_W-1:0]  regA,
  output logic [ADDR_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0]  exp_data,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [CYCLE_W-1:0] trace_cycle,
  output logic [ADDR_W-1:0]  trace_reg,
  output logic [DATA_W-1:0]  trace_data,
  output logic               trace_overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W:0]    error_count,
  output logic [ADDR_W-1:0]  first_fail_reg
);

  localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ERR_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = CYCLE_W + ADDR_W + DATA_W;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StCmp    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CYCLE_W-1:0] num_q, cycle_q;
  logic [ADDR_W-1:0]  idx_q, fail_q;
  logic [ERR_W-1:0]   err_q;

  logic [ENTRY_W-1:0] mem_q [TRACE_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic start_ok, in_run, last_cycle, last_idx, mismatch;
  logic push_req, push, pop, full;
  logic [ENTRY_W-1:0] head;

  assign start_ok   = start && (state_q == StIdle || state_q == StDone);
  assign in_run     = (state_q == StRun);
  assign last_cycle = (cycle_q == num_q - CYCLE_W'(1));
  assign last_idx   = (idx_q == ADDR_W'(NUM_REGS - 1));
  assign mismatch   = (regA != exp_data);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) state_d = (num_cycles == '0) ? StSettle : StRun;
      end
      StRun:    if (last_cycle) state_d = StSettle;
      StSettle: state_d = StCmp;
      StCmp:    state_d = last_idx ? StDone : StSettle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      num_q   <= '0;
      cycle_q <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_q   <= num_cycles;
        cycle_q <= '0;
        idx_q   <= '0;
        err_q   <= '0;
        fail_q  <= '0;
      end else begin
        if (in_run && !last_cycle) cycle_q <= cycle_q + CYCLE_W'(1);
        if (state_q == StCmp) begin
          if (mismatch) begin
            err_q <= err_q + ERR_W'(1);
            if (err_q == '0) fail_q <= idx_q;
          end
          if (!last_idx) idx_q <= idx_q + ADDR_W'(1);
        end
      end
    end
  end

  // Trace FIFO: a push into a full FIFO still lands if the head pops the same cycle.
  assign trace_valid = (cnt_q != '0);
  assign full        = (cnt_q == CNT_W'(TRACE_DEPTH));
  assign pop         = trace_valid && trace_ready;
  assign push_req    = in_run && rwe && (rd != '0);
  assign push        = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= {cycle_q, rd, rData};
  end

  always_ff @(posedge clock) begin
    if (!reset || start_ok) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign head           = mem_q[rptr_q];
  assign trace_cycle    = trace_valid ? head[ENTRY_W-1 -: CYCLE_W] : '0;
  assign trace_reg      = trace_valid ? head[DATA_W +: ADDR_W] : '0;
  assign trace_data     = trace_valid ? head[DATA_W-1:0] : '0;
  assign trace_overflow = ovf_q;

  assign test_mode      = (state_q == StSettle) || (state_q == StCmp);
  assign rs1_test       = test_mode ? idx_q : '0;
  assign exp_addr       = rs1_test;
  assign busy           = in_run || test_mode;
  assign done           = (state_q == StDone);
  assign pass           = done && (err_q == '0);
  assign error_count    = err_q;
  assign first_fail_reg = fail_q;

endmodule
